// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a small FIFO that streams encoded
// words into instruction memory at consecutive word addresses.
module instr_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic [2:0]                in_funct3,
  input  logic [6:0]                in_funct7,
  input  logic [31:0]               in_imm,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               word_cnt,
  output logic [7:0]                err_cnt,
  output logic [1:0]                err_code
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } fmt_e;

  fmt_e               fmt;
  logic [31:0]        enc;
  logic [1:0]         enc_err;
  logic signed [31:0] simm;

  logic [31:0]        fifo_q [DEPTH];
  logic [31:0]        fifo_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [1:0]         err_code_q, err_code_d;

  logic full, empty, accept, push, pop;

  assign simm = in_imm;

  // Classify the opcode, check the immediate and pack the instruction word
  always_comb begin
    fmt     = FMT_NONE;
    enc     = '0;
    enc_err = 2'd0;
    unique case (in_opcode)
      7'b0110011:                         fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
    case (fmt)
      FMT_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) enc_err = 2'd2;
      end
      FMT_S: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) enc_err = 2'd2;
      end
      FMT_B: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0]) enc_err = 2'd3;
        else if (simm < -32'sd4096 || simm > 32'sd4094) enc_err = 2'd2;
      end
      FMT_U: begin
        enc = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != '0) enc_err = 2'd2;
      end
      FMT_J: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0]) enc_err = 2'd3;
        else if (simm < -32'sd1048576 || simm > 32'sd1048574) enc_err = 2'd2;
      end
      default: enc_err = 2'd1;
    endcase
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (enc_err == 2'd0);
  assign pop      = !empty && mem_ready && !flush;

  // FIFO, address/word counters and error bookkeeping next state
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      mem_addr_d = BASE_ADDR;
      word_cnt_d = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = enc;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        mem_addr_d = mem_addr_q + ADDR_W'(4);
        word_cnt_d = word_cnt_q + 16'd1;
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    if (accept && enc_err != 2'd0) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      err_code_d = enc_err;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= BASE_ADDR;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_code_q <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  assign mem_we     = !empty;
  assign mem_wdata  = empty ? '0 : fifo_q[rd_ptr_q];
  assign mem_addr   = mem_addr_q;
  assign fifo_count = count_q;
  assign word_cnt   = word_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: constant vectors, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, mem_we, mem_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, mem_addr, mem_wdata;
  logic [2:0]  fifo_count;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  err_code;

  logic        flush2, in_valid2, in_ready2, mem_we2, mem_ready2;
  logic [3:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  fifo_count2;
  logic [15:0] word_cnt2;
  logic [7:0]  err_cnt2;
  logic [1:0]  err_code2;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .fifo_count(fifo_count), .word_cnt(word_cnt), .err_cnt(err_cnt), .err_code(err_code));

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(4'd12)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready2),
    .fifo_count(fifo_count2), .word_cnt(word_cnt2), .err_cnt(err_cnt2), .err_code(err_code2));

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [1:0]  err;
    logic [31:0] word;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [31:0] m_addr;
  logic [15:0] m_wcnt;
  int          m_ecnt;
  logic [1:0]  m_ecode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned fld(input longint unsigned u, input int lo, input int n);
    return (u >> lo) % (64'd1 << n);
  endfunction

  function automatic longint unsigned at(input longint unsigned v, input int pos);
    return v << pos;
  endfunction

  // returns {error code, encoded word}
  function automatic logic [33:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    longint          v;
    longint unsigned u, acc;
    logic [1:0]      e;
    v = longint'($signed(imm));
    u = longint'(imm) & 64'hFFFF_FFFF;
    e = 2'd0;
    acc = 0;
    case (op)
      7'b0110011:
        acc = at(f7, 25) + at(rs2, 20) + at(rs1, 15) + at(f3, 12) + at(rd, 7) + op;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (v < -2048 || v > 2047) e = 2'd2;
        acc = at(fld(u, 0, 12), 20) + at(rs1, 15) + at(f3, 12) + at(rd, 7) + op;
      end
      7'b0100011: begin
        if (v < -2048 || v > 2047) e = 2'd2;
        acc = at(fld(u, 5, 7), 25) + at(rs2, 20) + at(rs1, 15) + at(f3, 12)
            + at(fld(u, 0, 5), 7) + op;
      end
      7'b1100011: begin
        if (v % 2 != 0) e = 2'd3;
        else if (v < -4096 || v > 4094) e = 2'd2;
        acc = at(fld(u, 12, 1), 31) + at(fld(u, 5, 6), 25) + at(rs2, 20) + at(rs1, 15)
            + at(f3, 12) + at(fld(u, 1, 4), 8) + at(fld(u, 11, 1), 7) + op;
      end
      7'b0110111, 7'b0010111: begin
        if (v % 4096 != 0) e = 2'd2;
        acc = at(fld(u, 12, 20), 12) + at(rd, 7) + op;
      end
      7'b1101111: begin
        if (v % 2 != 0) e = 2'd3;
        else if (v < -(64'sd1 << 20) || v > (64'sd1 << 20) - 2) e = 2'd2;
        acc = at(fld(u, 20, 1), 31) + at(fld(u, 1, 10), 21) + at(fld(u, 11, 1), 20)
            + at(fld(u, 12, 8), 12) + at(rd, 7) + op;
      end
      default: e = 2'd1;
    endcase
    return {e, acc[31:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr  = 32'h0;
    m_wcnt  = '0;
    m_ecnt  = 0;
    m_ecode = 2'd0;
  endtask

  // check outputs against the model, then advance model and DUT one edge
  task automatic tick();
    logic [33:0] r;
    bit acc, pp;
    int sz;
    #1;
    sz = mq.size();
    chk("in_ready", 64'(in_ready), 64'((sz < DEPTH) && !flush));
    chk("mem_we", 64'(mem_we), 64'(sz > 0));
    if (sz > 0) chk("mem_wdata", 64'(mem_wdata), 64'(mq[0]));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("fifo_count", 64'(fifo_count), 64'(sz));
    chk("word_cnt", 64'(word_cnt), 64'(m_wcnt));
    chk("err_cnt", 64'(err_cnt), 64'(m_ecnt));
    chk("err_code", 64'(err_code), 64'(m_ecode));
    acc = in_valid && (sz < DEPTH) && !flush;
    pp  = (sz > 0) && mem_ready && !flush;
    if (flush) begin
      mq.delete();
      m_addr = 32'h0;
      m_wcnt = '0;
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
        m_wcnt = m_wcnt + 16'd1;
      end
      if (acc) begin
        r = ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        if (r[33:32] != 2'd0) begin
          if (m_ecnt < 255) m_ecnt++;
          m_ecode = r[33:32];
        end else mq.push_back(r[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input vec_t v);
    in_opcode = v.op;  in_rd = v.rd;   in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3;  in_funct7 = v.f7; in_imm = v.imm;
  endtask

  vec_t tbl[$];
  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                         7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  initial begin
    //         op          rd     rs1    rs2    f3    f7      imm            err   word
    tbl.push_back('{7'b0010011, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5,          2'd0, 32'h00500093});
    tbl.push_back('{7'b0100011, 5'd0, 5'd1, 5'd2,  3'd2, 7'h00, 32'd8,          2'd0, 32'h0020A423});
    tbl.push_back('{7'b1100011, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'hFFFFFFFC,   2'd0, 32'hFE208EE3});
    tbl.push_back('{7'b1101111, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd8,          2'd0, 32'h008000EF});
    tbl.push_back('{7'b0110111, 5'd5, 5'd9, 5'd0,  3'd7, 7'h00, 32'h12345000,   2'd0, 32'h123452B7});
    tbl.push_back('{7'b0110011, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 32'd0,          2'd0, 32'h002081B3});
    tbl.push_back('{7'b0110011, 5'd3, 5'd1, 5'd2,  3'd0, 7'h20, 32'd0,          2'd0, 32'h402081B3});
    tbl.push_back('{7'b1111111, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd0,          2'd1, 32'h0});
    tbl.push_back('{7'b0010011, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd2048,       2'd2, 32'h0});
    tbl.push_back('{7'b1101111, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd3,          2'd3, 32'h0});
    tbl.push_back('{7'b0010011, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFFF800,   2'd0, 32'h80000093});
    tbl.push_back('{7'b1100011, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'd4096,       2'd2, 32'h0});
    tbl.push_back('{7'b1100011, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'd4095,       2'd3, 32'h0});
    tbl.push_back('{7'b1100011, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'd4094,       2'd0, 32'h7E000FE3});
    tbl.push_back('{7'b0110111, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h00000001,   2'd2, 32'h0});
    tbl.push_back('{7'b1101111, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFF00000,   2'd0, 32'h8000006F});
    tbl.push_back('{7'b1101111, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'h00100000,   2'd2, 32'h0});
    tbl.push_back('{7'b0100011, 5'd0, 5'd1, 5'd2,  3'd2, 7'h00, 32'hFFFFFFFF,   2'd0, 32'hFE20AFA3});
    tbl.push_back('{7'b0010111, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h00001000,   2'd0, 32'h00001097});
    tbl.push_back('{7'b0000011, 5'd1, 5'd2, 5'd0,  3'd2, 7'h00, 32'd0,          2'd0, 32'h00012083});
    tbl.push_back('{7'b1100111, 5'd0, 5'd1, 5'd0,  3'd0, 7'h00, 32'd0,          2'd0, 32'h00008067});

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; mem_ready2 = 1'b0;
    set_req(tbl[0]);
    repeat (2) @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst fifo_count", 64'(fifo_count), 64'd0);
    chk("rst word_cnt", 64'(word_cnt), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    chk("rst err_code", 64'(err_code), 64'd0);
    rst = 1'b0;
    model_reset();

    // single addi after reset
    in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addi we", 64'(mem_we), 64'd1);
    chk("addi addr", 64'(mem_addr), 64'd0);
    chk("addi data", 64'(mem_wdata), 64'h00500093);
    tick();
    chk("addi word_cnt", 64'(word_cnt), 64'd1);
    chk("addi next addr", 64'(mem_addr), 64'd4);

    // back-to-back sw, beq, jal, lui
    for (int i = 1; i <= 4; i++) begin
      set_req(tbl[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("b2b word_cnt", 64'(word_cnt), 64'd5);
    chk("b2b addr", 64'(mem_addr), 64'd20);

    // backpressure: 5 requests, only 4 fit
    set_req(tbl[0]);
    mem_ready = 1'b0; in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    chk("full count", 64'(fifo_count), 64'd4);
    chk("full ready", 64'(in_ready), 64'd0);
    mem_ready = 1'b1;
    tick();
    chk("ready after pop", 64'(in_ready), 64'd1);
    repeat (3) tick();
    chk("drained count", 64'(fifo_count), 64'd0);
    chk("drained word_cnt", 64'(word_cnt), 64'd9);

    // flush with 3 queued words at address 0x20
    flush = 1'b1; tick(); flush = 1'b0;
    in_valid = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    tick();
    chk("pre-flush addr", 64'(mem_addr), 64'h20);
    mem_ready = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("pre-flush count", 64'(fifo_count), 64'd3);
    flush = 1'b1; mem_ready = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush count", 64'(fifo_count), 64'd0);
    chk("flush addr", 64'(mem_addr), 64'd0);
    chk("flush word_cnt", 64'(word_cnt), 64'd0);
    chk("flush err_cnt", 64'(err_cnt), 64'd0);
    chk("flush we", 64'(mem_we), 64'd0);

    // constant vector table
    for (int i = 0; i < tbl.size(); i++) begin
      set_req(tbl[i]);
      mem_ready = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (tbl[i].err == 2'd0) begin
        chk($sformatf("vec%0d we", i), 64'(mem_we), 64'd1);
        chk($sformatf("vec%0d word", i), 64'(mem_wdata), 64'(tbl[i].word));
      end else begin
        chk($sformatf("vec%0d we", i), 64'(mem_we), 64'd0);
        chk($sformatf("vec%0d err_code", i), 64'(err_code), 64'(tbl[i].err));
      end
      mem_ready = 1'b1;
      tick();
    end

    // err_cnt saturation
    set_req(tbl[7]);
    in_valid = 1'b1;
    repeat (256) tick();
    in_valid = 1'b0;
    chk("err_cnt sat", 64'(err_cnt), 64'd255);
    chk("err_code bad op", 64'(err_code), 64'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: in_imm = $urandom;
        2: in_imm = ($urandom & 32'h001FFFFE) - 32'h00100000;
        default: in_imm = $urandom & 32'hFFFFF000;
      endcase
      tick();
    end
    flush = 1'b0;

    // asynchronous reset mid-stream
    set_req(tbl[0]);
    mem_ready = 1'b0; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst we", 64'(mem_we), 64'd0);
    chk("async rst count", 64'(fifo_count), 64'd0);
    chk("async rst err_cnt", 64'(err_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // narrow address bus wraps from 12 to 0
    set_req(tbl[0]);
    in_valid2 = 1'b1; mem_ready2 = 1'b1;
    chk("w2 rst addr", 64'(mem_addr2), 64'd12);
    tick();
    chk("w2 we0", 64'(mem_we2), 64'd1);
    chk("w2 addr0", 64'(mem_addr2), 64'd12);
    tick();
    in_valid2 = 1'b0;
    chk("w2 we1", 64'(mem_we2), 64'd1);
    chk("w2 addr1", 64'(mem_addr2), 64'd0);
    chk("w2 data1", 64'(mem_wdata2), 64'h00500093);
    tick();
    chk("w2 idle", 64'(mem_we2), 64'd0);
    chk("w2 addr2", 64'(mem_addr2), 64'd4);
    chk("w2 word_cnt", 64'(word_cnt2), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
